riscv_muldiv: RTL
=================

Name: riscv_muldiv

Overview:
Iterative, multi-cycle integer multiply/divide unit implementing the RV32M operations. It sits beside riscv_alu in the execute stage and takes the same 32-bit operands `a` and `b`. It handles the operations the single-cycle ALU does not. A start/busy/done handshake lets the pipeline stall while the unit is computing.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
a  input  XLEN  rs1 operand (multiplicand / dividend).
b  input  XLEN  rs2 operand (multiplier / divisor).
busy  output  1  high while an operation is in flight.
done  output  1  single-cycle pulse; result is valid in this cycle.
result  output  XLEN  operation result; held until the next done.

Behaviour:
- Reset (rst=1 at an edge, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0. Any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, CALC, FIX.
  - IDLE: on start=1, capture op, a and b; latch operand signs per op; convert signed operands to magnitudes; counter=0; go to CALC.
  - CALC: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). counter increments each cycle; after XLEN steps (counter=XLEN-1 at the edge), go to FIX.
  - FIX: apply sign correction, select high/low product half or quotient/remainder, load result, pulse done, return to IDLE.
- busy = (state != IDLE).
- Fixed latency, independent of operand values and special cases:
  - start captured at edge E0.
  - busy=1 for the XLEN+1 cycles following E0.
  - done=1 and new result in the cycle after edge E(XLEN+1), i.e. 33 cycles after capture for XLEN=32.
- start while busy=1 is ignored; operands and op are not re-sampled. start asserted in the same cycle done=1 is accepted, since the state is already IDLE.
- Operand inputs may change freely after capture.
- Multiply:
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN] of the full 2*XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operand interpretation respectively.
- Divide:
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: DIV/DIVU return all-ones; REM/REMU return a unchanged. No exception is raised.
- Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- result changes only at the FIX→IDLE edge or on reset.
- done is never high for two consecutive cycles.

Test Plan:
1. Reset then idle: after rst, busy=0, done=0, result=0. Apply start with op=MUL, a=7, b=6 → busy high for 33 cycles; done pulses once, exactly 33 cycles after capture; result=0x0000002A.
2. Signed high products: MULH a=0xFFFFFFFF (-1), b=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0x00000002 → 0xFFFFFFFF.
3. Division signs: DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). DIVU a=0xFFFFFFF9, b=2 → 0x7FFFFFFC.
4. Special cases, each taking full 33-cycle latency:
   - DIV a=5, b=0 → 0xFFFFFFFF.
   - REMU a=5, b=0 → 5.
   - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000.
   - REM with the same operands → 0.
5. Handshake: pulse start with new operands at cycle 10 of a busy operation → ignored; the first result is unchanged. Assert start in the done cycle → the second operation is accepted back-to-back; its done comes 33 cycles later.
6. Reset mid-operation: assert rst at cycle 15 of a DIV → next cycle busy=0, done=0, result=0. No done pulse follows; a fresh start completes normally.

Source files
------------

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit.
// One radix-2 step per cycle. Latency is fixed and does not depend on the operands:
// capture, then XLEN steps, then one sign-fix cycle.
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    // hi: product upper half / partial remainder; lo: multiplier / dividend-quotient
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    // opd: multiplicand magnitude for multiply, divisor magnitude for divide
    logic [XLEN-1:0] opd_q, opd_d;
    logic            neg_main_q, neg_main_d;  // negate product / quotient
    logic            neg_rem_q, neg_rem_d;    // negate remainder
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    // Combinational temporaries
    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     shifted, diff, sum;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s;

    // Next-state logic: operand capture, one iteration step, and the final sign fix
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opd_d      = opd_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        done_d     = 1'b0;
        result_d   = result_q;

        // MUL, MULH, MULHSU, DIV and REM read rs1 as signed.
        // MUL, MULH, DIV and REM read rs2 as signed.
        // MUL keeps only the low half, so treating its operands as signed is harmless.
        a_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sa       = a_signed & a[XLEN-1];
        sb       = b_signed & b[XLEN-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;

        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opd_q};
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});

        prod_s = neg_main_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_s = neg_main_q ? -lo_q : lo_q;
        rem_s  = neg_rem_q ? -hi_q : hi_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    hi_d    = '0;
                    state_d = CALC;
                    if (op[2]) begin
                        lo_d       = mag_a;
                        opd_d      = mag_b;
                        // A zero divisor yields all ones, so its quotient is never negated.
                        neg_main_d = (sa ^ sb) & (b != '0);
                        neg_rem_d  = sa;
                    end else begin
                        lo_d       = mag_b;
                        opd_d      = mag_a;
                        neg_main_d = sa ^ sb;
                        neg_rem_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    // Restoring division step. diff[XLEN] set means the trial subtraction borrowed.
                    if (!diff[XLEN]) begin
                        hi_d = diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = shifted[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add multiply step. The product shifts right into lo as the multiplier drains out.
                    hi_d = sum[XLEN:1];
                    lo_d = {sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                case (op_q)
                    3'd0:          result_d = prod_s[XLEN-1:0];
                    3'd1, 3'd2,
                    3'd3:          result_d = prod_s[2*XLEN-1:XLEN];
                    3'd4, 3'd5:    result_d = quot_s;
                    default:       result_d = rem_s;
                endcase
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opd_q      <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opd_q      <= opd_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
